// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32 pipeline.
// Owns the PC, issues instruction-memory requests, and parks one acked
// instruction in a skid buffer while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsel,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_ins,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buf_ins, buf_ins_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic        ifid_valid_n;
    logic [31:0] ifid_ins_n;
    logic [31:0] ifid_pc_n;
    logic [31:0] ifid_pc4_n;

    // Requests go out only while fetching; the address is always the live PC.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Register all fetch state; a redirect or reset squashes any same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST;
            pc         <= RESET_PC;
            buf_ins    <= NOP_INS;
            buf_pc     <= 32'h0000_0000;
            ifid_valid <= 1'b0;
            ifid_ins   <= NOP_INS;
            ifid_pc    <= 32'h0000_0000;
            ifid_pc4   <= 32'h0000_0000;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            buf_ins    <= buf_ins_n;
            buf_pc     <= buf_pc_n;
            ifid_valid <= ifid_valid_n;
            ifid_ins   <= ifid_ins_n;
            ifid_pc    <= ifid_pc_n;
            ifid_pc4   <= ifid_pc4_n;
        end
    end

    // Next-state logic: redirect beats stall, stall beats normal advance.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        buf_ins_n    = buf_ins;
        buf_pc_n     = buf_pc;
        ifid_valid_n = ifid_valid;
        ifid_ins_n   = ifid_ins;
        ifid_pc_n    = ifid_pc;
        ifid_pc4_n   = ifid_pc4;

        if (pcsel) begin
            pc_n         = {pc_target[31:2], 2'b00};
            ifid_valid_n = 1'b0;
            ifid_ins_n   = NOP_INS;
            buf_ins_n    = NOP_INS;
            buf_pc_n     = 32'h0000_0000;
            state_n      = FETCH;
        end else begin
            case (state)
                RST: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (imem_ack && !stall) begin
                        ifid_valid_n = 1'b1;
                        ifid_ins_n   = imem_rdata;
                        ifid_pc_n    = pc;
                        ifid_pc4_n   = pc + 32'd4;
                        pc_n         = pc + 32'd4;
                    end else if (imem_ack && stall) begin
                        buf_ins_n = imem_rdata;
                        buf_pc_n  = pc;
                        pc_n      = pc + 32'd4;
                        state_n   = HOLD;
                    end else if (!imem_ack && !stall) begin
                        ifid_valid_n = 1'b0;
                        ifid_ins_n   = NOP_INS;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid_n = 1'b1;
                        ifid_ins_n   = buf_ins;
                        ifid_pc_n    = buf_pc;
                        ifid_pc4_n   = buf_pc + 32'd4;
                        state_n      = FETCH;
                    end
                end
                default: begin
                    state_n = RST;
                end
            endcase
        end
    end

endmodule
